btn_pulse_gen: RTL and testbench

BTN_PULSE_GEN -- requirements
Module: btn_pulse_gen

---
 rtl/btn_pulse_gen.sv | 114 +++++++++++
 tb/tb_btn_pulse_gen.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/btn_pulse_gen.sv
// Push-button conditioner: 2-flop synchronizer, DEBOUNCE_LEN-sample debouncer and press-strobe FSM.
// Define BTN_REPEAT_EN to add auto-repeat pulses while the button stays held.
module btn_pulse_gen #(
  parameter int DEBOUNCE_LEN  = 4,
  parameter int HOLD_CYCLES   = 50,
  parameter int REPEAT_CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_in,
  output logic pb_debounced,
  output logic pb_pulse
);

`ifdef BTN_REPEAT_EN
  typedef enum logic [1:0] {RELEASED, PRESSED, REPEATING} state_t;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  logic [HW-1:0] hold_cnt, hold_next;
  logic [RW-1:0] rep_cnt, rep_next;
`else
  typedef enum logic {RELEASED, PRESSED} state_t;
  localparam int unused_repeat_cfg = HOLD_CYCLES + REPEAT_CYCLES;
`endif

  logic [1:0]              sync;
  logic [DEBOUNCE_LEN-1:0] hist;
  logic                    all_ones, all_zeros, rise, fall;
  logic                    deb_next, pulse_next;
  state_t                  state, state_next;

  assign all_ones  = &hist;
  assign all_zeros = ~|hist;
  assign rise      = all_ones & ~pb_debounced;
  assign fall      = all_zeros & pb_debounced;

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync         <= '0;
      hist         <= '0;
      pb_debounced <= 1'b0;
      pb_pulse     <= 1'b0;
      state        <= RELEASED;
    end else begin
      sync         <= {sync[0], pb_in};
      hist         <= {hist[DEBOUNCE_LEN-2:0], sync[1]};
      pb_debounced <= deb_next;
      pb_pulse     <= pulse_next;
      state        <= state_next;
    end
  end

`ifdef BTN_REPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
      rep_cnt  <= '0;
    end else begin
      hold_cnt <= hold_next;
      rep_cnt  <= rep_next;
    end
  end
`endif

  // NOTE: every output of this block is defaulted first so no latch is inferred.
  always_comb begin
    state_next = state;
    pulse_next = 1'b0;
    deb_next   = pb_debounced;
    if (all_ones)       deb_next = 1'b1;
    else if (all_zeros) deb_next = 1'b0;
`ifdef BTN_REPEAT_EN
    hold_next = '0;
    rep_next  = '0;
`endif
    case (state)
      RELEASED: begin
        if (rise) begin
          state_next = PRESSED;
          pulse_next = 1'b1;
        end
      end
      PRESSED: begin
        if (fall) begin
          state_next = RELEASED;
`ifdef BTN_REPEAT_EN
        end else if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
          state_next = REPEATING;
          pulse_next = 1'b1;
          hold_next  = hold_cnt;
        end else begin
          hold_next = (hold_cnt == HW'(HOLD_CYCLES)) ? hold_cnt : hold_cnt + 1'b1;
`endif
        end
      end
`ifdef BTN_REPEAT_EN
      REPEATING: begin
        hold_next = hold_cnt;
        if (fall) begin
          state_next = RELEASED;
          hold_next  = '0;
        end else if (rep_cnt == RW'(REPEAT_CYCLES - 1)) begin
          pulse_next = 1'b1;
        end else begin
          rep_next = (rep_cnt == RW'(REPEAT_CYCLES)) ? rep_cnt : rep_cnt + 1'b1;
        end
      end
`endif
      default: state_next = RELEASED;
    endcase
  end

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Self-checking bench for btn_pulse_gen: directed scenarios plus random button activity
// compared each cycle against a sample-window reference model.
module tb_btn_pulse_gen;
  localparam int L    = 4;
  localparam int HOLD = 50;
  localparam int REP  = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pb_in = 1'b0;
  logic pb_debounced, pb_pulse;

  btn_pulse_gen #(.DEBOUNCE_LEN(L), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut (
    .clk(clk), .rst(rst), .pb_in(pb_in),
    .pb_debounced(pb_debounced), .pb_pulse(pb_pulse)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model: raw[0] is the newest sample of pb_in
  logic raw[$];
  logic deb_m = 1'b0;
  logic pulse_m = 1'b0;
  int   held = 0;

  // per-scenario observations
  int   edge_cnt, n_pulse, first_edge, deb_seen;
  logic last_pulse = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    raw = {};
    for (int i = 0; i < L + 3; i++) raw.push_back(1'b0);
    deb_m = 1'b0; pulse_m = 1'b0; held = 0;
  endtask

  task automatic model_edge();
    logic prev, ones, zeros;
    if (rst) begin
      model_clear();
      return;
    end
    raw.push_front(pb_in);
    void'(raw.pop_back());
    // a raw sample reaches the debounce window three edges after it is taken
    ones = 1'b1; zeros = 1'b1;
    for (int i = 3; i < L + 3; i++) begin
      if (raw[i] !== 1'b1) ones = 1'b0;
      if (raw[i] !== 1'b0) zeros = 1'b0;
    end
    prev = deb_m;
    if (ones) deb_m = 1'b1;
    else if (zeros) deb_m = 1'b0;
    pulse_m = deb_m & ~prev;
    if (pulse_m) held = 0;
    else if (deb_m) held++;
`ifdef BTN_REPEAT_EN
    if (deb_m && prev && held >= HOLD && ((held - HOLD) % REP) == 0) pulse_m = 1'b1;
`endif
  endtask

  task automatic seg_start();
    edge_cnt = 0; n_pulse = 0; first_edge = 0; deb_seen = 0;
  endtask

  // called at a falling edge: drive, take one rising edge, check at the next falling edge
  task automatic step(input logic r, input logic p);
    rst = r; pb_in = p;
    @(posedge clk);
    model_edge();
    edge_cnt++;
    @(negedge clk);
    check("pb_debounced", pb_debounced, deb_m);
    check("pb_pulse", pb_pulse, pulse_m);
    if (pb_pulse === 1'b1) begin
      check("pulse_back2back", last_pulse, 0);
      n_pulse++;
      if (first_edge == 0) first_edge = edge_cnt;
    end
    if (pb_debounced === 1'b1) deb_seen = 1;
    last_pulse = pb_pulse;
  endtask

  task automatic drive(input logic p, input int n);
    for (int i = 0; i < n; i++) step(1'b0, p);
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    seg_start();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    check("reset_deb", pb_debounced, 0);
    check("reset_pulse", pb_pulse, 0);
    step(1'b0, 1'b0);
    drive(1'b0, 8);

    // steady press: strobe at edge 7, held long enough to stay below the repeat threshold
    seg_start();
    drive(1'b1, 40);
    check("press_first_edge", first_edge, 7);
    check("press_pulses", n_pulse, 1);
    drive(1'b0, 12);
    check("press_after_release", n_pulse, 1);

    // short glitch of 3 samples
    seg_start();
    drive(1'b1, 3);
    drive(1'b0, 12);
    check("glitch_pulses", n_pulse, 0);
    check("glitch_deb", deb_seen, 0);

    // bouncing press then steady
    seg_start();
    step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b1); step(1'b0, 1'b0);
    drive(1'b1, 20);
    check("bounce_pulses", n_pulse, 1);
    check("bounce_latency_ok", int'(first_edge >= 5 && first_edge <= 5 + L + 3), 1);
    drive(1'b0, 12);

    // reset during a held press
    seg_start();
    drive(1'b1, 9);
    step(1'b1, 1'b1);
    check("midrst_deb", pb_debounced, 0);
    check("midrst_pulse", pb_pulse, 0);
    step(1'b1, 1'b1);
    seg_start();
    drive(1'b1, 20);
    check("midrst_first_edge", first_edge, 7);
    check("midrst_pulses", n_pulse, 1);
    drive(1'b0, 12);

    // two separate presses
    seg_start();
    drive(1'b1, 15); drive(1'b0, 10); drive(1'b1, 15); drive(1'b0, 12);
    check("two_press_pulses", n_pulse, 2);

    // 100-cycle hold
    seg_start();
    drive(1'b1, 100);
    drive(1'b0, 15);
    check("long_first_edge", first_edge, 7);
`ifdef BTN_REPEAT_EN
    check("long_pulses", n_pulse, 6);
`else
    check("long_pulses", n_pulse, 1);
`endif

    // random activity
    for (int s = 0; s < 120; s++) begin
      case ($urandom_range(0, 5))
        0: drive(1'b1, $urandom_range(1, L - 1));
        1: drive(1'b1, $urandom_range(5, 130));
        2: drive(1'b0, $urandom_range(1, 20));
        3: for (int i = 0; i < int'($urandom_range(1, 8)); i++) step(1'b0, 1'($urandom));
        4: for (int i = 0; i < int'($urandom_range(1, 3)); i++) step(1'b1, 1'($urandom));
        default: drive(1'b0, $urandom_range(8, 15));
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
